// File: rtl/dtc_rr_sched.sv
// Round-robin scheduler sharing one combinational decision-tree classifier among N_REQ requesters.
// Optional per-class response counters are enabled by defining DTC_SCHED_STATS_EN.
module dtc_rr_sched #(
    parameter int N_REQ  = 4,
    parameter int IN_W   = 12,
    parameter int OUT_W  = 3,
    parameter int ID_W   = 2,
    parameter int STAT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*IN_W-1:0]   req_data,
    output logic [IN_W-1:0]         cls_inp,
    input  logic [OUT_W-1:0]        cls_outp,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [OUT_W-1:0]        rsp_class,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy,
    input  logic [OUT_W-1:0]        stat_sel,
    output logic [STAT_W-1:0]       stat_cnt
);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_cur_id;
    logic [IN_W-1:0]   r_cls_inp;
    logic              r_rsp_valid;
    logic [OUT_W-1:0]  r_rsp_class;
    logic [ID_W-1:0]   r_rsp_id;

    logic              w_any;
    logic [ID_W-1:0]   w_grant;
    logic [IN_W-1:0]   w_sel_data;
    logic              w_accept;

    // Search starts just after the last grant; descending k lets the nearest candidate win.
    function automatic logic [ID_W-1:0] rr_pick(input logic [ID_W-1:0] ptr,
                                                input logic [N_REQ-1:0] v);
        logic [ID_W-1:0] g;
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        g = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ))
                idx = ID_W'(sum - (ID_W+1)'(N_REQ));
            else
                idx = ID_W'(sum);
            if (v[idx])
                g = idx;
        end
        return g;
    endfunction

    always_comb begin
        w_any      = |req_valid;
        w_grant    = rr_pick(r_rr_ptr, req_valid);
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant == ID_W'(i))
                w_sel_data = req_data[i*IN_W +: IN_W];
        end
        w_accept  = rst_n && (r_state == IDLE) && w_any;
        req_ready = w_accept ? (N_REQ'(1) << w_grant) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= ID_W'(N_REQ - 1);
            r_cur_id    <= '0;
            r_cls_inp   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_class <= '0;
            r_rsp_id    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_cls_inp <= w_sel_data;
                        r_cur_id  <= w_grant;
                        r_rr_ptr  <= w_grant;
                        r_state   <= EVAL;
                    end
                end
                EVAL: begin
                    r_rsp_class <= cls_outp;
                    r_rsp_id    <= r_cur_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cls_inp   = r_cls_inp;
    assign rsp_valid = r_rsp_valid;
    assign rsp_class = r_rsp_class;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != IDLE);

`ifdef DTC_SCHED_STATS_EN
    logic [STAT_W-1:0] r_stat [2**OUT_W];

    // Counters saturate rather than wrap so a long run never reads as a small count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < 2**OUT_W; c++)
                r_stat[c] <= '0;
        end else if (r_rsp_valid && rsp_ready) begin
            if (r_stat[r_rsp_class] != {STAT_W{1'b1}})
                r_stat[r_rsp_class] <= r_stat[r_rsp_class] + STAT_W'(1);
        end
    end

    assign stat_cnt = r_stat[stat_sel];
`else
    logic w_unused_stat_sel;
    assign w_unused_stat_sel = ^stat_sel;
    assign stat_cnt          = '0;
`endif

endmodule
